cfc_ckpt: RTL and testbench

CFC_CKPT -- requirements
Module: cfc_ckpt

---
 rtl/cfc_ckpt_pkg.sv | 23 ++
 rtl/cfc_ckpt_mem.sv | 24 ++
 rtl/cfc_ckpt.sv | 132 +++++++++++++
 tb/tb_cfc_ckpt.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cfc_ckpt_pkg.sv
// Shared processor constants: free register list sizing and branch checkpoint defaults.
// Also holds the resolve-event decode used by the checkpoint controller.
package cfc_ckpt_pkg;

  localparam int FRL_NUM_REGS      = 32;
  localparam int FRL_PTR_WIDTH_DEF = $clog2(FRL_NUM_REGS);
  localparam int CKPT_DEPTH_DEF    = 4;
  localparam int TAG_WIDTH_DEF     = $clog2(CKPT_DEPTH_DEF);

  typedef enum logic [1:0] {
    RES_NONE    = 2'd0,
    RES_CORRECT = 2'd1,
    RES_MISPRED = 2'd2
  } res_kind_e;

  // A resolve naming a checkpoint that is not live is treated as no event at all.
  function automatic res_kind_e res_decode(input logic resolve, input logic mispredict,
                                           input logic tag_valid);
    if (!resolve || !tag_valid) return RES_NONE;
    return mispredict ? RES_MISPRED : RES_CORRECT;
  endfunction

endpackage

// File: rtl/cfc_ckpt_mem.sv
// Saved free-register-list pointer per checkpoint: one synchronous write port,
// one asynchronous read port. Contents are not reset.
module cfc_ckpt_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cfc_ckpt.sv
// Branch checkpoint queue: saves the FRL read pointer per in-flight branch, releases
// resolved branches in order, and on a mispredict squashes younger entries and restores the pointer.
module cfc_ckpt
  import cfc_ckpt_pkg::*;
#(
  parameter int FRL_PTR_WIDTH = FRL_PTR_WIDTH_DEF,
  parameter int CKPT_DEPTH    = CKPT_DEPTH_DEF,
  parameter int TAG_WIDTH     = TAG_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     du_branch_dispatch,
  input  logic [FRL_PTR_WIDTH-1:0] frl_rd_ptr,
  output logic [TAG_WIDTH-1:0]     cfc_ckpt_tag,
  output logic                     cfc_full,
  input  logic                     bpu_resolve,
  input  logic [TAG_WIDTH-1:0]     bpu_resolve_tag,
  input  logic                     bpu_mispredict,
  output logic                     cfc_flush_frl,
  output logic [FRL_PTR_WIDTH-1:0] cfc_flush_frl_value
);

  localparam logic [TAG_WIDTH:0] FULL_CNT = (TAG_WIDTH+1)'(CKPT_DEPTH);
  localparam logic [TAG_WIDTH-1:0] TAG_ONE = TAG_WIDTH'(1);

  logic [TAG_WIDTH-1:0]     head_q, head_d;
  logic [TAG_WIDTH-1:0]     tail_q, tail_d;
  logic [TAG_WIDTH:0]       count_q, count_d;
  logic [CKPT_DEPTH-1:0]    valid_q, valid_d;
  logic [CKPT_DEPTH-1:0]    resolved_q, resolved_d;
  logic                     flush_q, flush_d;
  logic [FRL_PTR_WIDTH-1:0] flush_val_q, flush_val_d;

  logic [CKPT_DEPTH-1:0]    kill_mask;
  logic [TAG_WIDTH-1:0]     mis_dist;
  logic [FRL_PTR_WIDTH-1:0] saved_ptr;
  res_kind_e                res_kind;
  logic                     mispredict;
  logic                     release_head;
  logic                     release_eff;
  logic                     accept;

  assign cfc_full     = (count_q == FULL_CNT);
  assign cfc_ckpt_tag = tail_q;

  assign res_kind     = res_decode(bpu_resolve, bpu_mispredict, valid_q[bpu_resolve_tag]);
  assign mispredict   = (res_kind == RES_MISPRED);
  assign release_head = valid_q[head_q] & resolved_q[head_q];
  assign accept       = du_branch_dispatch & ~cfc_full & ~mispredict;
  assign mis_dist     = bpu_resolve_tag - head_q;
  // A mispredict on the head itself empties the queue, so the head release is moot.
  assign release_eff  = release_head & ~(mispredict & (mis_dist == '0));

  // Live entries are contiguous from head, so "T and younger" is every live entry
  // whose age offset from head is at least that of T.
  always_comb begin
    kill_mask = '0;
    for (int i = 0; i < CKPT_DEPTH; i++) begin
      kill_mask[i] = valid_q[i] && (TAG_WIDTH'(TAG_WIDTH'(i) - head_q) >= mis_dist);
    end
  end

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    valid_d     = valid_q;
    resolved_d  = resolved_q;
    flush_d     = mispredict;
    flush_val_d = flush_val_q;

    if (res_kind == RES_CORRECT) resolved_d[bpu_resolve_tag] = 1'b1;

    if (release_eff) begin
      valid_d[head_q]    = 1'b0;
      resolved_d[head_q] = 1'b0;
      head_d             = head_q + TAG_ONE;
    end

    if (mispredict) begin
      valid_d     = valid_d & ~kill_mask;
      resolved_d  = resolved_d & ~kill_mask;
      tail_d      = bpu_resolve_tag;
      flush_val_d = saved_ptr;
      count_d     = {1'b0, mis_dist} - (TAG_WIDTH+1)'(release_eff);
    end else begin
      if (accept) begin
        valid_d[tail_q]    = 1'b1;
        resolved_d[tail_q] = 1'b0;
        tail_d             = tail_q + TAG_ONE;
      end
      count_d = count_q + (TAG_WIDTH+1)'(accept) - (TAG_WIDTH+1)'(release_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      resolved_q  <= '0;
      flush_q     <= 1'b0;
      flush_val_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      resolved_q  <= resolved_d;
      flush_q     <= flush_d;
      flush_val_q <= flush_val_d;
    end
  end

  assign cfc_flush_frl       = flush_q;
  assign cfc_flush_frl_value = flush_val_q;

  cfc_ckpt_mem #(
    .DEPTH (CKPT_DEPTH),
    .WIDTH (FRL_PTR_WIDTH),
    .AW    (TAG_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (tail_q),
    .wdata_i (frl_rd_ptr),
    .raddr_i (bpu_resolve_tag),
    .rdata_o (saved_ptr)
  );

endmodule

// File: tb/tb_cfc_ckpt.sv
// Directed bench for cfc_ckpt: fill/full, in-order release, mispredict recovery,
// wrap-around squash of the oldest entry, and reset suppressing a pending flush.
module tb_cfc_ckpt;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       du_branch_dispatch = 1'b0;
  logic [4:0] frl_rd_ptr = '0;
  logic [1:0] cfc_ckpt_tag;
  logic       cfc_full;
  logic       bpu_resolve = 1'b0;
  logic [1:0] bpu_resolve_tag = '0;
  logic       bpu_mispredict = 1'b0;
  logic       cfc_flush_frl;
  logic [4:0] cfc_flush_frl_value;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cfc_ckpt dut (
    .clk                 (clk),
    .reset               (reset),
    .du_branch_dispatch  (du_branch_dispatch),
    .frl_rd_ptr          (frl_rd_ptr),
    .cfc_ckpt_tag        (cfc_ckpt_tag),
    .cfc_full            (cfc_full),
    .bpu_resolve         (bpu_resolve),
    .bpu_resolve_tag     (bpu_resolve_tag),
    .bpu_mispredict      (bpu_mispredict),
    .cfc_flush_frl       (cfc_flush_frl),
    .cfc_flush_frl_value (cfc_flush_frl_value)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic dispatch(input logic [4:0] ptr, input logic [1:0] exp_tag, input string tag);
    du_branch_dispatch = 1'b1;
    frl_rd_ptr         = ptr;
    check(tag, cfc_ckpt_tag, exp_tag);
    step();
    du_branch_dispatch = 1'b0;
  endtask

  task automatic resolve(input logic [1:0] t, input logic mis);
    bpu_resolve     = 1'b1;
    bpu_resolve_tag = t;
    bpu_mispredict  = mis;
    step();
    bpu_resolve     = 1'b0;
    bpu_mispredict  = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_flush",     cfc_flush_frl,       0);
    check("rst_flush_val", cfc_flush_frl_value, 0);
    check("rst_full",      cfc_full,            0);
    check("rst_tag",       cfc_ckpt_tag,        0);

    // Fill all four checkpoints, then try a fifth.
    dispatch(5'd3,  2'd0, "fill_tag0");
    dispatch(5'd7,  2'd1, "fill_tag1");
    dispatch(5'd9,  2'd2, "fill_tag2");
    check("not_full_at3", cfc_full, 0);
    dispatch(5'd12, 2'd3, "fill_tag3");
    check("full_at4", cfc_full, 1);
    dispatch(5'd20, 2'd0, "fifth_tag");
    check("fifth_full",  cfc_full,      1);
    check("fifth_count", dut.count_q,   4);
    check("fifth_tag_hold", cfc_ckpt_tag, 0);

    // Head resolves; release cycle coincides with a dispatch that is still blocked by full.
    resolve(2'd0, 1'b0);
    check("full_before_rel", cfc_full, 1);
    du_branch_dispatch = 1'b1;
    frl_rd_ptr         = 5'd21;
    step();
    du_branch_dispatch = 1'b0;
    check("rel0_head",  dut.head_q,   1);
    check("rel0_full",  cfc_full,     0);
    check("rel0_count", dut.count_q,  3);
    check("rel0_tag",   cfc_ckpt_tag, 0);

    // Out-of-order resolve, in-order release.
    resolve(2'd2, 1'b0);
    check("ooo_no_rel", dut.head_q, 1);
    resolve(2'd1, 1'b0);
    check("rel1_pending", dut.head_q, 1);
    step();
    check("rel1_head", dut.head_q, 2);
    step();
    check("rel2_head",  dut.head_q,  3);
    check("rel2_count", dut.count_q, 1);

    // Mispredict tag 1 with all four live.
    do_reset();
    dispatch(5'd3,  2'd0, "m_tag0");
    dispatch(5'd7,  2'd1, "m_tag1");
    dispatch(5'd9,  2'd2, "m_tag2");
    dispatch(5'd12, 2'd3, "m_tag3");
    check("m_flush_idle", cfc_flush_frl, 0);
    resolve(2'd1, 1'b1);
    check("m1_flush",     cfc_flush_frl,       1);
    check("m1_flush_val", cfc_flush_frl_value, 7);
    check("m1_tail",      cfc_ckpt_tag,        1);
    check("m1_count",     dut.count_q,         1);
    check("m1_full",      cfc_full,            0);
    check("m1_head",      dut.head_q,          0);
    step();
    check("m1_flush_once", cfc_flush_frl, 0);
    dispatch(5'd15, 2'd1, "m1_redispatch");
    check("m1_redisp_count", dut.count_q, 2);

    // Mispredict tag 2 with a simultaneous dispatch, then a mispredict on a dead tag.
    dispatch(5'd9, 2'd2, "m2_tag2");
    bpu_resolve        = 1'b1;
    bpu_resolve_tag    = 2'd2;
    bpu_mispredict     = 1'b1;
    du_branch_dispatch = 1'b1;
    frl_rd_ptr         = 5'd30;
    step();
    bpu_resolve        = 1'b0;
    bpu_mispredict     = 1'b0;
    du_branch_dispatch = 1'b0;
    check("m2_flush",     cfc_flush_frl,       1);
    check("m2_flush_val", cfc_flush_frl_value, 9);
    check("m2_tail",      cfc_ckpt_tag,        2);
    check("m2_count",     dut.count_q,         2);
    step();
    check("m2_flush_once", cfc_flush_frl, 0);
    resolve(2'd3, 1'b1);
    check("dead_no_flush", cfc_flush_frl, 0);
    check("dead_count",    dut.count_q,   2);
    check("dead_tail",     cfc_ckpt_tag,  2);

    // Advance head to 2 so the queue wraps, then squash the oldest entry.
    do_reset();
    dispatch(5'd1, 2'd0, "w_tag0");
    dispatch(5'd2, 2'd1, "w_tag1");
    resolve(2'd0, 1'b0);
    step();
    resolve(2'd1, 1'b0);
    step();
    check("w_head",  dut.head_q,  2);
    check("w_empty", dut.count_q, 0);
    dispatch(5'd4, 2'd2, "w_tag2");
    dispatch(5'd5, 2'd3, "w_tag3");
    dispatch(5'd6, 2'd0, "w_wrap0");
    dispatch(5'd8, 2'd1, "w_wrap1");
    check("w_full", cfc_full,     1);
    check("w_tail", cfc_ckpt_tag, 2);
    resolve(2'd2, 1'b1);
    check("wm_flush",     cfc_flush_frl,       1);
    check("wm_flush_val", cfc_flush_frl_value, 4);
    check("wm_count",     dut.count_q,         0);
    check("wm_full",      cfc_full,            0);
    check("wm_tail",      cfc_ckpt_tag,        2);
    check("wm_head",      dut.head_q,          2);
    step();
    check("wm_flush_once", cfc_flush_frl, 0);

    // Reset coinciding with a mispredict must swallow the flush.
    dispatch(5'd10, 2'd2, "r_tag2");
    dispatch(5'd11, 2'd3, "r_tag3");
    reset           = 1'b1;
    bpu_resolve     = 1'b1;
    bpu_resolve_tag = 2'd2;
    bpu_mispredict  = 1'b1;
    step();
    reset           = 1'b0;
    bpu_resolve     = 1'b0;
    bpu_mispredict  = 1'b0;
    check("r_no_flush",  cfc_flush_frl,       0);
    check("r_flush_val", cfc_flush_frl_value, 0);
    check("r_tag",       cfc_ckpt_tag,        0);
    check("r_full",      cfc_full,            0);
    check("r_count",     dut.count_q,         0);
    step();
    check("r_no_flush_late", cfc_flush_frl, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
